// File: rtl/shim_trigger_seq.sv
// shim_trigger_seq
//   Trigger sequencer for the shim system. Executes a command stream from an
//   external command FIFO and issues a stretched trigger pulse to all DAC/ADC
//   channel cores. Each trigger is logged as a two-word record
//   (timestamp low word, then source + timestamp high bits) into the data FIFO.
//
//   Command word: [31:29] type, [28:0] value
//     1 SYNC_CH      trigger once every masked channel reports waiting
//     2 SET_LOCKOUT  ext-trigger lockout length in cycles (>= LOCKOUT_MIN)
//     3 EXPECT_EXT   wait for n honoured external rising edges
//     4 DELAY        wait n cycles
//     5 FORCE_TRIG   trigger immediately
//     6 SET_MASK     sync channel mask, bits [N_DAC-1:0] = DAC (must be nonzero)
//     7 CANCEL       abort the current wait, clear counters and pulse
//     0              illegal
//
//   Handshakes: cmd_word_rd_en is combinational and pops the command FIFO in
//   the same cycle the head word is consumed; it is only asserted while
//   cmd_buf_empty is low. data_word_wr_en is registered and is only raised for
//   a record that was accepted when the data FIFO reported room for both words.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cmd_word_rd_en              pop command FIFO
//   cmd_word, cmd_buf_empty     command FIFO head and empty flag
//   data_word_wr_en, data_word  data FIFO write strobe and word
//   data_buf_full               data FIFO full
//   data_buf_almost_full        data FIFO has fewer than two free entries
//   ext_trig                    external trigger (already synchronous)
//   dac/adc_waiting_for_trig    per-channel waiting flags
//   trig_out                    trigger pulse, PULSE_CYCLES wide
//   trig_count                  triggers since reset, saturating
//   data_buf_overflow           sticky: a trigger record was dropped
//   bad_cmd                     sticky: an illegal command was consumed
module shim_trigger_seq #(
   parameter int N_DAC           = 8,
   parameter int N_ADC           = 8,
   parameter int TS_WIDTH        = 48,
   parameter int LOCKOUT_DEFAULT = 5000,
   parameter int LOCKOUT_MIN     = 4,
   parameter int PULSE_CYCLES    = 1
) (
   input  logic             clk,
   input  logic             rst,
   output logic             cmd_word_rd_en,
   input  logic [31:0]      cmd_word,
   input  logic             cmd_buf_empty,
   output logic             data_word_wr_en,
   output logic [31:0]      data_word,
   input  logic             data_buf_full,
   input  logic             data_buf_almost_full,
   input  logic             ext_trig,
   input  logic [N_DAC-1:0] dac_waiting_for_trig,
   input  logic [N_ADC-1:0] adc_waiting_for_trig,
   output logic             trig_out,
   output logic [31:0]      trig_count,
   output logic             data_buf_overflow,
   output logic             bad_cmd
);

   localparam int NCH = N_DAC + N_ADC;
   localparam int PW  = $clog2(PULSE_CYCLES + 1);

   localparam logic [2:0] CMD_SYNC    = 3'd1;
   localparam logic [2:0] CMD_LOCKOUT = 3'd2;
   localparam logic [2:0] CMD_EXPECT  = 3'd3;
   localparam logic [2:0] CMD_DELAY   = 3'd4;
   localparam logic [2:0] CMD_FORCE   = 3'd5;
   localparam logic [2:0] CMD_MASK    = 3'd6;
   localparam logic [2:0] CMD_CANCEL  = 3'd7;

   localparam logic [2:0] SRC_SYNC  = 3'd1;
   localparam logic [2:0] SRC_EXT   = 3'd2;
   localparam logic [2:0] SRC_FORCE = 3'd3;

   localparam logic [28:0]         LOCK_MIN   = 29'(LOCKOUT_MIN);
   localparam logic [28:0]         LOCK_RST   = 29'(LOCKOUT_DEFAULT);
   localparam logic [PW-1:0]       PULSE_LOAD = PW'(PULSE_CYCLES);
   localparam logic [TS_WIDTH-1:0] TS_ONE     = TS_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SYNC   = 3'd1,
      S_EXPECT = 3'd2,
      S_DELAY  = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

   state_t state, state_nxt;

   // Registers
   logic [28:0]          cnt;          // EXPECT edges left / DELAY cycles left
   logic [28:0]          lockout_val;
   logic [28:0]          lockout_cnt;
   logic [NCH-1:0]       mask;
   logic                 ext_q;
   logic [PW-1:0]        pulse_cnt;
   logic [TS_WIDTH-1:0]  timer;
   logic                 rec_stage;    // word1 of the current record goes out next
   logic [2:0]           rec_src;
   logic [TS_WIDTH-33:0] rec_ts_hi;

   // Decode / control
   logic [2:0]  cmd_type;
   logic [28:0] cmd_val;
   logic        all_waiting;
   logic        ext_rise;
   logic        head_cancel;
   logic        accept;
   logic        do_trig;
   logic [2:0]  trig_src;
   logic        cancel;
   logic        load_cnt;
   logic        load_lockout;
   logic        load_mask;
   logic        set_bad;
   logic        ext_honour;
   logic        rec_drop;
   logic [31:0] word1;

   assign cmd_type    = cmd_word[31:29];
   assign cmd_val     = cmd_word[28:0];
   // Unmasked channels count as waiting.
   assign all_waiting = &(~mask | {adc_waiting_for_trig, dac_waiting_for_trig});
   assign ext_rise    = ext_trig & ~ext_q;
   assign head_cancel = ~cmd_buf_empty & (cmd_type == CMD_CANCEL);
   assign trig_out    = (pulse_cnt != '0);

   // A record needs two free entries and an idle write path; anything else drops it.
   assign rec_drop = data_buf_full | data_buf_almost_full | rec_stage | data_word_wr_en;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state and command execution
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt      = state;
      accept         = 1'b0;
      cmd_word_rd_en = 1'b0;
      do_trig        = 1'b0;
      trig_src       = 3'd0;
      cancel         = 1'b0;
      load_cnt       = 1'b0;
      load_lockout   = 1'b0;
      load_mask      = 1'b0;
      set_bad        = 1'b0;
      ext_honour     = 1'b0;

      case (state)
         S_IDLE: accept = 1'b1;
         S_SYNC: begin
            // Completing a sync returns to IDLE without also consuming the
            // next word, so two triggers can never land in one cycle.
            if (head_cancel) begin
               accept = 1'b1;
            end else if (all_waiting) begin
               do_trig   = 1'b1;
               trig_src  = SRC_SYNC;
               state_nxt = S_IDLE;
            end
         end
         S_EXPECT: begin
            // Done is seen the cycle after the final honoured edge.
            if (head_cancel || (cnt == '0)) begin
               accept = 1'b1;
            end else if (ext_rise && (lockout_cnt == '0)) begin
               ext_honour = 1'b1;
               do_trig    = 1'b1;
               trig_src   = SRC_EXT;
            end
         end
         S_DELAY: begin
            // cnt == 1 is the last of the n delay cycles.
            if (head_cancel || (cnt == 29'd1)) begin
               accept = 1'b1;
            end
         end
         default: ;  // S_ERROR holds until reset
      endcase

      if (accept) begin
         state_nxt = S_IDLE;
         if (!cmd_buf_empty) begin
            cmd_word_rd_en = 1'b1;
            case (cmd_type)
               CMD_SYNC: begin
                  if (all_waiting) begin
                     do_trig  = 1'b1;
                     trig_src = SRC_SYNC;
                  end else begin
                     state_nxt = S_SYNC;
                  end
               end
               CMD_LOCKOUT: begin
                  if (cmd_val < LOCK_MIN) begin
                     set_bad   = 1'b1;
                     state_nxt = S_ERROR;
                  end else begin
                     load_lockout = 1'b1;
                  end
               end
               CMD_EXPECT: begin
                  if (cmd_val != '0) begin
                     load_cnt  = 1'b1;
                     state_nxt = S_EXPECT;
                  end
               end
               CMD_DELAY: begin
                  if (cmd_val != '0) begin
                     load_cnt  = 1'b1;
                     state_nxt = S_DELAY;
                  end
               end
               CMD_FORCE: begin
                  do_trig  = 1'b1;
                  trig_src = SRC_FORCE;
               end
               CMD_MASK: begin
                  if (cmd_val[NCH-1:0] == '0) begin
                     set_bad   = 1'b1;
                     state_nxt = S_ERROR;
                  end else begin
                     load_mask = 1'b1;
                  end
               end
               CMD_CANCEL: cancel = 1'b1;
               default: begin
                  set_bad   = 1'b1;
                  state_nxt = S_ERROR;
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------
   // Configuration and counters
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         lockout_val <= LOCK_RST;
         mask        <= '1;
         ext_q       <= 1'b0;
         bad_cmd     <= 1'b0;
      end else begin
         ext_q <= ext_trig;
         if (load_lockout) lockout_val <= cmd_val;
         if (load_mask)    mask        <= cmd_val[NCH-1:0];
         if (set_bad)      bad_cmd     <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (cancel) begin
         cnt <= '0;
      end else if (load_cnt) begin
         cnt <= cmd_val;
      end else if (ext_honour || ((state == S_DELAY) && (cnt != '0))) begin
         cnt <= cnt - 29'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lockout_cnt <= '0;
      end else if (cancel) begin
         lockout_cnt <= '0;
      end else if (ext_honour) begin
         lockout_cnt <= lockout_val;
      end else if (lockout_cnt != '0) begin
         lockout_cnt <= lockout_cnt - 29'd1;
      end
   end

   // ---------------------------------------------------------------------
   // Trigger pulse, count and timestamp
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pulse_cnt  <= '0;
         trig_count <= '0;
         timer      <= '0;
      end else begin
         if (cancel) begin
            pulse_cnt <= '0;
         end else if (do_trig) begin
            pulse_cnt <= PULSE_LOAD;
         end else if (pulse_cnt != '0) begin
            pulse_cnt <= pulse_cnt - 1'b1;
         end

         if (do_trig && (trig_count != '1)) begin
            trig_count <= trig_count + 32'd1;
         end

         // Timer sits at 0 until the first trigger; nonzero means it is running.
         if ((do_trig || (timer != '0)) && (timer != '1)) begin
            timer <= timer + TS_ONE;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Record writer: word0 at N+1, word1 at N+2
   // ---------------------------------------------------------------------
   always_comb begin
      word1                 = '0;
      word1[31:29]          = rec_src;
      word1[TS_WIDTH-33:0]  = rec_ts_hi;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_word_wr_en   <= 1'b0;
         data_word         <= '0;
         rec_stage         <= 1'b0;
         rec_src           <= '0;
         rec_ts_hi         <= '0;
         data_buf_overflow <= 1'b0;
      end else begin
         data_word_wr_en <= 1'b0;
         if (rec_stage) begin
            data_word_wr_en <= 1'b1;
            data_word       <= word1;
            rec_stage       <= 1'b0;
         end else if (do_trig && !rec_drop) begin
            data_word_wr_en <= 1'b1;
            data_word       <= timer[31:0];
            rec_ts_hi       <= timer[TS_WIDTH-1:32];
            rec_src         <= trig_src;
            rec_stage       <= 1'b1;
         end
         if (do_trig && rec_drop) begin
            data_buf_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_shim_trigger_seq.sv
// Bench for shim_trigger_seq: directed command sequences with a model command
// FIFO, expected data words and trigger cycles pushed into queues, and a
// negedge monitor that pops and compares whenever the DUT presents output.
module tb_shim_trigger_seq;

   localparam int N_DAC = 8;
   localparam int N_ADC = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   // ---------------- DUT signals ----------------
   logic             cmd_word_rd_en;
   logic [31:0]      cmd_word = 32'h0;
   logic             cmd_buf_empty = 1'b1;
   logic             data_word_wr_en;
   logic [31:0]      data_word;
   logic             data_buf_full = 1'b0;
   logic             data_buf_almost_full = 1'b0;
   logic             ext_trig = 1'b0;
   logic [N_DAC-1:0] dac_waiting = '0;
   logic [N_ADC-1:0] adc_waiting = '0;
   logic             trig_out;
   logic [31:0]      trig_count;
   logic             data_buf_overflow;
   logic             bad_cmd;

   shim_trigger_seq #(
      .N_DAC(N_DAC), .N_ADC(N_ADC), .TS_WIDTH(48),
      .LOCKOUT_DEFAULT(5000), .LOCKOUT_MIN(4), .PULSE_CYCLES(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cmd_word_rd_en(cmd_word_rd_en),
      .cmd_word(cmd_word),
      .cmd_buf_empty(cmd_buf_empty),
      .data_word_wr_en(data_word_wr_en),
      .data_word(data_word),
      .data_buf_full(data_buf_full),
      .data_buf_almost_full(data_buf_almost_full),
      .ext_trig(ext_trig),
      .dac_waiting_for_trig(dac_waiting),
      .adc_waiting_for_trig(adc_waiting),
      .trig_out(trig_out),
      .trig_count(trig_count),
      .data_buf_overflow(data_buf_overflow),
      .bad_cmd(bad_cmd)
   );

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];      // expected data FIFO words
   int          exp_trig_q[$]; // expected cycles with trig_out high
   logic [31:0] cmd_q[$];      // model command FIFO

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mk(input logic [2:0] t, input logic [28:0] v);
      return {t, v};
   endfunction

   task automatic expect_record(input logic [2:0] src, input logic [47:0] ts);
      exp_q.push_back(ts[31:0]);
      exp_q.push_back({src, 13'd0, ts[47:32]});
   endtask

   // ---------------- model command FIFO ----------------
   // Pops land at +1 after the edge, pushes from drivers too; outputs refresh at +2.
   always @(posedge clk) begin : cmd_fifo
      logic pop_now;
      pop_now = cmd_word_rd_en;
      #1;
      if (pop_now && (cmd_q.size() > 0)) void'(cmd_q.pop_front());
      #1;
      cmd_buf_empty = (cmd_q.size() == 0);
      cmd_word      = (cmd_q.size() == 0) ? 32'h0 : cmd_q[0];
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor
      logic [31:0] e;
      int          et;
      if (!rst) begin
         if (data_word_wr_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL data_word: got %08h, expected no write (cycle %0d)", data_word, cyc);
            end else begin
               e = exp_q.pop_front();
               check32("data_word", data_word, e);
            end
         end
         if (trig_out) begin
            if (exp_trig_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL trig_out: got pulse at cycle %0d, expected none", cyc);
            end else begin
               et = exp_trig_q.pop_front();
               check32("trig_cycle", cyc, et);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [31:0] w);
      cmd_q.push_back(w);
   endtask

   task automatic drain_check(input string name);
      check32({name, "_words_left"}, exp_q.size(), 0);
      check32({name, "_trigs_left"}, exp_trig_q.size(), 0);
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1;
      cmd_q.delete();
      ext_trig = 1'b0;
      dac_waiting = '0;
      adc_waiting = '0;
      data_buf_full = 1'b0;
      data_buf_almost_full = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      exp_q.delete();
      exp_trig_q.delete();
      #2;
      check32("rst_trig_out", trig_out, 0);
      check32("rst_trig_count", trig_count, 0);
      check32("rst_wr_en", data_word_wr_en, 0);
      check32("rst_data_word", data_word, 0);
      check32("rst_overflow", data_buf_overflow, 0);
      check32("rst_bad_cmd", bad_cmd, 0);
      check32("rst_rd_en", cmd_word_rd_en, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int k0, k1, e;
      logic [31:0] bad_vec [3];
      bad_vec[0] = mk(3'd2, 29'd3);        // lockout below minimum
      bad_vec[1] = mk(3'd6, 29'h10000);    // mask with no channel bits set
      bad_vec[2] = 32'h0000_0000;          // type 0

      // 1: single FORCE
      do_reset();
      tick();
      k0 = cyc;
      push_cmd(mk(3'd5, 29'd0));
      exp_trig_q.push_back(k0 + 1);
      expect_record(3'd3, 48'd0);
      repeat (6) tick();
      check32("force_trig_count", trig_count, 1);
      check32("force_overflow", data_buf_overflow, 0);
      drain_check("force");

      // 2: SYNC with mask = DAC channel 0 only
      do_reset();
      tick();
      dac_waiting = 8'hFE;
      adc_waiting = 8'hFF;
      push_cmd(mk(3'd6, 29'h00001));
      push_cmd(mk(3'd1, 29'd0));
      repeat (6) tick();
      check32("sync_wait_count", trig_count, 0);
      k0 = cyc;
      dac_waiting = 8'h01;
      adc_waiting = 8'h00;
      exp_trig_q.push_back(k0 + 1);
      expect_record(3'd1, 48'd0);
      repeat (6) tick();
      check32("sync_trig_count", trig_count, 1);
      drain_check("sync");

      // 3: lockout 10, expect 3, edges every 4 cycles
      do_reset();
      tick();
      push_cmd(mk(3'd2, 29'd4));
      push_cmd(mk(3'd2, 29'd10));
      push_cmd(mk(3'd3, 29'd3));
      repeat (4) tick();
      e = cyc;
      exp_trig_q.push_back(e + 1);
      exp_trig_q.push_back(e + 13);
      exp_trig_q.push_back(e + 25);
      expect_record(3'd2, 48'd0);
      expect_record(3'd2, 48'd12);
      expect_record(3'd2, 48'd24);
      for (int i = 0; i < 9; i++) begin
         ext_trig = 1'b1;
         tick();
         tick();
         ext_trig = 1'b0;
         tick();
         tick();
      end
      repeat (4) tick();
      check32("ext_trig_count", trig_count, 3);
      check32("ext_bad_cmd", bad_cmd, 0);
      drain_check("ext");

      // 4: DELAY 100 cancelled at cycle 20, then FORCE runs at once
      do_reset();
      tick();
      k0 = cyc;
      push_cmd(mk(3'd4, 29'd100));
      repeat (20) tick();
      push_cmd(mk(3'd7, 29'd0));
      push_cmd(mk(3'd5, 29'd0));
      exp_trig_q.push_back(k0 + 22);
      expect_record(3'd3, 48'd0);
      repeat (8) tick();
      check32("cancel_trig_count", trig_count, 1);
      drain_check("cancel");

      // 5: illegal commands -> ERROR, nothing further consumed
      for (int i = 0; i < 3; i++) begin
         do_reset();
         tick();
         push_cmd(bad_vec[i]);
         @(negedge clk);
         check32("bad_cmd_consume_cycle", bad_cmd, 0);
         tick();
         check32("bad_cmd_next_cycle", bad_cmd, 1);
         push_cmd(mk(3'd5, 29'd0));
         repeat (5) tick();
         check32("err_bad_cmd_sticky", bad_cmd, 1);
         check32("err_not_consumed", cmd_q.size(), 1);
         check32("err_trig_count", trig_count, 0);
         drain_check("err");
      end

      // 6: back-to-back FORCE -> second record dropped
      do_reset();
      tick();
      k0 = cyc;
      push_cmd(mk(3'd5, 29'd0));
      push_cmd(mk(3'd5, 29'd0));
      exp_trig_q.push_back(k0 + 1);
      exp_trig_q.push_back(k0 + 2);
      expect_record(3'd3, 48'd0);
      tick();
      check32("b2b_overflow_early", data_buf_overflow, 0);
      tick();
      check32("b2b_overflow", data_buf_overflow, 1);
      repeat (5) tick();
      check32("b2b_trig_count", trig_count, 2);
      drain_check("b2b");

      // 7: almost-full drops the record, timer keeps running
      do_reset();
      tick();
      k0 = cyc;
      data_buf_almost_full = 1'b1;
      push_cmd(mk(3'd5, 29'd0));
      exp_trig_q.push_back(k0 + 1);
      repeat (3) tick();
      check32("afull_overflow", data_buf_overflow, 1);
      check32("afull_trig_count", trig_count, 1);
      data_buf_almost_full = 1'b0;
      tick();
      k1 = cyc;
      push_cmd(mk(3'd5, 29'd0));
      exp_trig_q.push_back(k1 + 1);
      expect_record(3'd3, 48'(k1 - k0));
      repeat (6) tick();
      check32("afull_trig_count2", trig_count, 2);
      drain_check("afull");

      // reset clears the sticky flags
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
